// File: rtl/writeback_register_file.sv
// Architectural register file with a pending-write scoreboard. Commits writeback results,
// serves two combinational read ports with same-cycle bypass and tracks outstanding producers.
module writeback_register_file #(
  parameter int unsigned DATABITWIDTH    = 16,
  parameter int unsigned REGADDRBITWIDTH = 4
) (
  input  logic                       clk,
  input  logic                       sync_rst,
  input  logic                       WritebackEn,
  input  logic [REGADDRBITWIDTH-1:0] WritebackAddr,
  input  logic [DATABITWIDTH-1:0]    WritebackData,
  input  logic                       ReserveEn,
  input  logic [REGADDRBITWIDTH-1:0] ReserveAddr,
  input  logic [REGADDRBITWIDTH-1:0] ReadAAddr,
  input  logic [REGADDRBITWIDTH-1:0] ReadBAddr,
  output logic [DATABITWIDTH-1:0]    ReadAData,
  output logic [DATABITWIDTH-1:0]    ReadBData,
  output logic                       ReadAPending,
  output logic                       ReadBPending,
  output logic [REGADDRBITWIDTH:0]   PendingCount
);

  localparam int unsigned NumRegs = 2 ** REGADDRBITWIDTH;

  logic [DATABITWIDTH-1:0]  regs_q [NumRegs];
  logic [NumRegs-1:0]       pend_q, pend_d;
  logic [REGADDRBITWIDTH:0] count_q, count_d;
  logic                     wr_valid, rsv_valid;

  assign wr_valid  = WritebackEn && (WritebackAddr != '0);
  assign rsv_valid = ReserveEn && (ReserveAddr != '0);

  // Reserve is applied after the clear so a same-edge new producer keeps the flag set.
  always_comb begin
    pend_d = pend_q;
    if (wr_valid) begin
      pend_d[WritebackAddr] = 1'b0;
    end
    if (rsv_valid) begin
      pend_d[ReserveAddr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      count_d = count_d + (REGADDRBITWIDTH + 1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_valid) begin
        regs_q[WritebackAddr] <= WritebackData;
      end
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign PendingCount = count_q;

  always_comb begin
    ReadAData    = '0;
    ReadAPending = 1'b0;
    if (ReadAAddr == '0) begin
      ReadAData    = '0;
      ReadAPending = 1'b0;
    end else if (WritebackEn && (WritebackAddr == ReadAAddr)) begin
      ReadAData    = WritebackData;
      ReadAPending = 1'b0;
    end else begin
      ReadAData    = regs_q[ReadAAddr];
      ReadAPending = pend_q[ReadAAddr];
    end
  end

  always_comb begin
    ReadBData    = '0;
    ReadBPending = 1'b0;
    if (ReadBAddr == '0) begin
      ReadBData    = '0;
      ReadBPending = 1'b0;
    end else if (WritebackEn && (WritebackAddr == ReadBAddr)) begin
      ReadBData    = WritebackData;
      ReadBPending = 1'b0;
    end else begin
      ReadBData    = regs_q[ReadBAddr];
      ReadBPending = pend_q[ReadBAddr];
    end
  end

endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: reset, bypass, scoreboard set/clear and count.
module tb_writeback_register_file;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        wb_en, rsv_en;
  logic [3:0]  wb_addr, rsv_addr, ra_addr, rb_addr;
  logic [15:0] wb_data;
  logic [15:0] ra_data, rb_data;
  logic        ra_pend, rb_pend;
  logic [4:0]  pend_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_regs [16];
  logic [15:0] exp_pend;

  writeback_register_file #(
    .DATABITWIDTH   (16),
    .REGADDRBITWIDTH(4)
  ) dut (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .WritebackEn  (wb_en),
    .WritebackAddr(wb_addr),
    .WritebackData(wb_data),
    .ReserveEn    (rsv_en),
    .ReserveAddr  (rsv_addr),
    .ReadAAddr    (ra_addr),
    .ReadBAddr    (rb_addr),
    .ReadAData    (ra_data),
    .ReadBData    (rb_data),
    .ReadAPending (ra_pend),
    .ReadBPending (rb_pend),
    .PendingCount (pend_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later still.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i);
      rb_addr = 4'(15 - i);
      #1;
      check_eq({tag, "_a_data"}, 32'(ra_data), 32'h0);
      check_eq({tag, "_a_pend"}, 32'(ra_pend), 32'h0);
      check_eq({tag, "_b_data"}, 32'(rb_data), 32'h0);
      check_eq({tag, "_b_pend"}, 32'(rb_pend), 32'h0);
    end
    check_eq({tag, "_count"}, 32'(pend_count), 32'd0);
  endtask

  logic [3:0] rsv_seq [16] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7,
                               4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  logic [3:0] wb_seq  [6]  = '{4'd9, 4'd2, 4'd14, 4'd2, 4'd7, 4'd11};

  initial begin
    sync_rst = 1'b1;
    wb_en    = 1'b0; wb_addr  = '0; wb_data = '0;
    rsv_en   = 1'b0; rsv_addr = '0;
    ra_addr  = '0;   rb_addr  = '0;
    step();
    step();
    sync_rst = 1'b0;
    check_all_zero("rst");

    // Reserve r5, then write it back with bypass.
    rsv_en = 1'b1; rsv_addr = 4'd5;
    step();
    rsv_en = 1'b0; ra_addr = 4'd5; rb_addr = 4'd5;
    #1;
    check_eq("r5_pend_after_rsv", 32'(ra_pend), 32'h1);
    check_eq("r5_count_after_rsv", 32'(pend_count), 32'd1);
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
    #1;
    check_eq("r5_bypass_a_data", 32'(ra_data), 32'hBEEF);
    check_eq("r5_bypass_a_pend", 32'(ra_pend), 32'h0);
    check_eq("r5_bypass_b_data", 32'(rb_data), 32'hBEEF);
    check_eq("r5_count_pre_edge", 32'(pend_count), 32'd1);
    step();
    wb_en = 1'b0;
    #1;
    check_eq("r5_array_data", 32'(ra_data), 32'hBEEF);
    check_eq("r5_array_pend", 32'(ra_pend), 32'h0);
    check_eq("r5_count_after_wb", 32'(pend_count), 32'd0);

    // Same edge reserve and writeback on r3: data lands, new producer keeps it pending.
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
    rsv_en = 1'b1; rsv_addr = 4'd3;
    step();
    wb_en = 1'b0; rsv_en = 1'b0; ra_addr = 4'd3;
    #1;
    check_eq("r3_both_data", 32'(ra_data), 32'h1234);
    check_eq("r3_both_pend", 32'(ra_pend), 32'h1);
    check_eq("r3_both_count", 32'(pend_count), 32'd1);

    // Register 0 ignores writes and reserves.
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0; ra_addr = 4'd0;
    #1;
    check_eq("r0_bypass_data", 32'(ra_data), 32'h0);
    check_eq("r0_bypass_pend", 32'(ra_pend), 32'h0);
    step();
    wb_en = 1'b0; rsv_en = 1'b0;
    #1;
    check_eq("r0_data", 32'(ra_data), 32'h0);
    check_eq("r0_pend", 32'(ra_pend), 32'h0);
    check_eq("r0_count", 32'(pend_count), 32'd1);

    // Fill the scoreboard (r3 already pending, r7 reserved twice).
    exp_pend = 16'h0008;
    for (int i = 0; i < 16; i++) begin
      rsv_en = 1'b1; rsv_addr = rsv_seq[i];
      step();
      exp_pend[rsv_seq[i]] = 1'b1;
      rsv_en = 1'b0;
      #1;
      check_eq("fill_count", 32'(pend_count), 32'($countones(exp_pend)));
    end
    check_eq("fill_count_full", 32'(pend_count), 32'd15);
    ra_addr = 4'd15; rb_addr = 4'd1;
    #1;
    check_eq("fill_r15_pend", 32'(ra_pend), 32'h1);
    check_eq("fill_r1_pend", 32'(rb_pend), 32'h1);

    // Writebacks clear one each; the second r2 hits a non-pending register.
    for (int i = 0; i < 6; i++) begin
      wb_en = 1'b1; wb_addr = wb_seq[i]; wb_data = 16'hA000 + 16'(i);
      step();
      exp_pend[wb_seq[i]] = 1'b0;
      wb_en = 1'b0; ra_addr = wb_seq[i]; rb_addr = 4'd15;
      #1;
      check_eq("drain_count", 32'(pend_count), 32'($countones(exp_pend)));
      check_eq("drain_data", 32'(ra_data), 32'(16'hA000 + 16'(i)));
      check_eq("drain_pend", 32'(ra_pend), 32'h0);
      check_eq("drain_r15_pend", 32'(rb_pend), 32'h1);
    end
    check_eq("drain_count_final", 32'(pend_count), 32'd10);

    // Reset mid-operation discards everything, including a same-cycle writeback.
    rsv_en = 1'b1; rsv_addr = 4'd2;
    step();
    rsv_addr = 4'd9;
    step();
    rsv_en = 1'b0;
    #1;
    check_eq("pre_rst_count", 32'(pend_count), 32'd12);
    sync_rst = 1'b1;
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h00AA;
    step();
    sync_rst = 1'b0; wb_en = 1'b0;
    check_all_zero("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
